// File: rtl/conveng_pkg.sv
// conveng_pkg: shared types and helpers for the convolution-engine pixel ingest
package conveng_pkg;
  localparam int ROWS_MAX = 8;
  localparam int PB_DEFAULT = 8;
  typedef logic [PB_DEFAULT-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} px_lb_state_t;
  function automatic int rot_idx(int base, int off, int n);
    return base + off >= n ? base + off - n : base + off;
  endfunction
endpackage

// File: rtl/px_line_ram.sv
// px_line_ram: simple dual-port line RAM, registered read with enable, read-before-write
module px_line_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // read sees the old word when the same address is written in the same cycle
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/px_line_buffer.sv
// px_line_buffer: raster stream to vertical ROWS-pixel columns; PX_EDGE_REPLICATE_EN clamps the top edge so every pixel emits
module px_line_buffer import conveng_pkg::*; #(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int ROWS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XB-1:0]    cfg_width,
  input  logic [YB-1:0]    cfg_height,
  input  logic [PB-1:0]    px_in_data,
  input  logic             px_in_valid,
  output logic             px_in_ready,
  output logic [ROWS*PB-1:0] px_out_data,
  output logic [XB-1:0]    px_out_x,
  output logic [YB-1:0]    px_out_y,
  output logic             px_out_last_x,
  output logic             px_out_last_y,
  output logic             px_out_valid,
  input  logic             px_out_ready,
  output logic             done,
  output logic             busy
);
  localparam int NR = ROWS - 1;
  localparam int RB = NR > 1 ? $clog2(NR) : 1;
  px_lb_state_t state, nxt;
  logic [XB-1:0] x, wq, ox;
  logic [YB-1:0] y, hq, oy;
  logic [RB-1:0] wr_row, row_q;
  logic [PB-1:0] px_q;
  logic [PB-1:0] rd [NR];
  logic [ROWS*PB-1:0] col;
  logic ov, olx, oly, ok, acc, emit, eol, lasty, eof, go;
  int d;
  assign ok = !ov || px_out_ready;
  assign acc = state == RUN && px_in_valid && ok;
  assign eol = x == wq - XB'(1);
  assign lasty = y == hq - YB'(1);
  assign eof = eol && lasty;
  assign go = start && cfg_width != '0 && cfg_height != '0;
`ifdef PX_EDGE_REPLICATE_EN
  assign emit = 1'b1;
`else
  assign emit = 32'(y) >= ROWS - 1;
`endif
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state and handshake/status outputs
  always_comb begin
    nxt = state;
    px_in_ready = 1'b0;
    done = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: nxt = go ? RUN : IDLE;
      RUN: begin
        px_in_ready = ok;
        nxt = acc && eof ? FLUSH : RUN;
      end
      FLUSH: nxt = ok ? DONE : FLUSH;
      DONE: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // raster counters, line slot rotation and the output stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wq <= '0;
      hq <= '0;
      x <= '0;
      y <= '0;
      wr_row <= '0;
      row_q <= '0;
      px_q <= '0;
      ox <= '0;
      oy <= '0;
      olx <= 1'b0;
      oly <= 1'b0;
      ov <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        wq <= cfg_width;
        hq <= cfg_height;
        x <= '0;
        y <= '0;
        wr_row <= '0;
      end
      if (acc) begin
        x <= eol ? '0 : x + 1'b1;
        y <= eol ? y + 1'b1 : y;
        wr_row <= eol ? (wr_row == RB'(NR - 1) ? '0 : wr_row + 1'b1) : wr_row;
        row_q <= wr_row;
        px_q <= px_in_data;
        ox <= x;
        oy <= y;
        olx <= eol;
        oly <= lasty;
        ov <= emit;
      end else if (px_out_ready) begin
        ov <= 1'b0;
      end
    end
  end
  for (genvar i = 0; i < NR; i++) begin : g_ram
    px_line_ram #(.AW(XB), .DW(PB)) u_ram (
      .clk(clk),
      .we(acc && wr_row == RB'(i)),
      .waddr(x),
      .wdata(px_in_data),
      .re(acc),
      .raddr(x),
      .rdata(rd[i])
    );
  end
  // column assembly: slot wr_row holds the oldest line; d is the distance back from the newest row
  always_comb begin
    col = '0;
    d = 0;
    for (int i = 0; i < NR; i++) begin
      d = ROWS - 1 - i;
`ifdef PX_EDGE_REPLICATE_EN
      if (d > int'(oy)) d = int'(oy);
`endif
      col[i*PB +: PB] = d == 0 ? px_q : rd[RB'(rot_idx(int'(row_q), NR - d, NR))];
    end
    col[NR*PB +: PB] = px_q;
  end
  assign px_out_data = ov ? col : '0;
  assign px_out_x = ox;
  assign px_out_y = oy;
  assign px_out_last_x = olx;
  assign px_out_last_y = oly;
  assign px_out_valid = ov;
endmodule

// File: tb/tb_px_line_buffer.sv
// tb_px_line_buffer: random and directed frames checked against a frame-array model of the column stream
module tb_px_line_buffer;
  localparam int XB = 10, YB = 10, PB = 8, ROWS = 3;
`ifdef PX_EDGE_REPLICATE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  typedef struct packed {
    logic [ROWS*PB-1:0] d;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic lx;
    logic ly;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [XB-1:0] cfg_width = '0;
  logic [YB-1:0] cfg_height = '0;
  logic [PB-1:0] px_in_data = '0;
  logic px_in_valid = 1'b0, px_in_ready;
  logic [ROWS*PB-1:0] px_out_data;
  logic [XB-1:0] px_out_x;
  logic [YB-1:0] px_out_y;
  logic px_out_last_x, px_out_last_y, px_out_valid, done, busy;
  logic px_out_ready = 1'b0;
  exp_t q[$];
  exp_t held;
  logic [PB-1:0] frame [0:15][0:15];
  logic [ROWS*PB-1:0] log_d [0:15][0:15];
  int checks = 0, failures = 0, cyc = 0;
  int mw, mh, mx, my, acc_cnt, out_cnt, last_out_cyc, done_cnt = 0, ready_mode = 0;
  bit in_fire = 0, prev_done = 0, stalled = 0;

  px_line_buffer #(.XB(XB), .YB(YB), .PB(PB), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .px_in_data(px_in_data), .px_in_valid(px_in_valid), .px_in_ready(px_in_ready),
    .px_out_data(px_out_data), .px_out_x(px_out_x), .px_out_y(px_out_y),
    .px_out_last_x(px_out_last_x), .px_out_last_y(px_out_last_y),
    .px_out_valid(px_out_valid), .px_out_ready(px_out_ready), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model_accept();
    exp_t e;
    int r;
    frame[my][mx] = px_in_data;
    acc_cnt++;
    if (EDGE || my >= ROWS - 1) begin
      e.d = '0;
      for (int i = 0; i < ROWS; i++) begin
        r = my - ROWS + 1 + i;
        if (r < 0) r = 0;
        e.d[i*PB +: PB] = frame[r][mx];
      end
      e.x = XB'(mx);
      e.y = YB'(my);
      e.lx = mx == mw - 1;
      e.ly = my == mh - 1;
      q.push_back(e);
    end
    if (mx == mw - 1) begin
      mx = 0;
      my++;
    end else mx++;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      in_fire = 0;
      prev_done = 0;
      stalled = 0;
    end else begin
      in_fire = px_in_valid && px_in_ready;
      if (stalled && px_out_valid) chk("stall_hold", {px_out_data, px_out_x, px_out_y, px_out_last_x, px_out_last_y}, held);
      if (px_out_valid) begin
        if (!px_out_ready) chk("in_ready_during_stall", px_in_ready, 0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_output actual=x%0d,y%0d expected=no output", px_out_x, px_out_y);
        end else chk("column", {px_out_data, px_out_x, px_out_y, px_out_last_x, px_out_last_y}, q[0]);
        if (px_out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          if (px_out_x < 16 && px_out_y < 16) log_d[px_out_y][px_out_x] = px_out_data;
          out_cnt++;
          last_out_cyc = cyc;
        end
      end
      stalled = px_out_valid && !px_out_ready;
      held = {px_out_data, px_out_x, px_out_y, px_out_last_x, px_out_last_y};
      if (done) begin
        chk("done_one_cycle", prev_done, 0);
        if (out_cnt > 0) chk("done_latency", cyc, last_out_cyc + 1);
        done_cnt++;
      end
      prev_done = done;
      if (in_fire) model_accept();
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: px_out_ready = 1'b1;
      1: px_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: px_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic start_frame(input int w, input int h);
    mw = w;
    mh = h;
    mx = 0;
    my = 0;
    acc_cnt = 0;
    out_cnt = 0;
    @(posedge clk);
    #1;
    cfg_width = XB'(w);
    cfg_height = YB'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input int w, input bit pat, input bit rvalid, input int stop_at);
    int idx = 0, g = 0;
    px_in_valid = 1'b0;
    while (idx < stop_at && g < 5000) begin
      if (!px_in_valid && (!rvalid || $urandom_range(0, 3) != 0)) begin
        px_in_data = pat ? PB'((idx / w) * 16 + idx % w) : PB'($urandom);
        px_in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      g++;
      if (in_fire) begin
        idx++;
        px_in_valid = 1'b0;
      end
    end
    px_in_valid = 1'b0;
    if (idx < stop_at) begin
      checks++;
      failures++;
      $display("FAIL feed_timeout actual=%0d accepted expected=%0d", idx, stop_at);
    end
  endtask

  task automatic wait_done(input int base);
    int g = 0;
    while (done_cnt == base && g < 400) begin
      @(posedge clk);
      g++;
    end
    chk("done_seen", done_cnt, base + 1);
    @(posedge clk);
    #1;
    chk("idle_after_done", busy, 0);
    chk("drained", q.size(), 0);
  endtask

  task automatic run(input int w, input int h, input bit pat, input bit rvalid);
    int base;
    base = done_cnt;
    start_frame(w, h);
    feed(w, pat, rvalid, w * h);
    wait_done(base);
    chk("accepted", acc_cnt, w * h);
  endtask

  initial begin
    int base, w, h;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", px_out_valid, 0);
    chk("rst_busy", busy, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", px_in_ready, 0);
    chk("idle_done", done, 0);
    // zero dimension start is ignored
    cfg_width = '0;
    cfg_height = YB'(4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("zero_width_ignored", busy, 0);
    ready_mode = 0;
    run(4, 4, 1, 0);
    chk("frame4x4_count", out_cnt, EDGE ? 16 : 8);
    chk("frame4x4_first", log_d[2][0], 24'h201000);
    chk("frame4x4_last", log_d[3][3], 24'h332313);
`ifdef PX_EDGE_REPLICATE_EN
    chk("edge_x1_y0", log_d[0][1], 24'h010101);
    chk("edge_x1_y1", log_d[1][1], 24'h110101);
`endif
    ready_mode = 1;
    run(4, 4, 1, 0);
    chk("stall_frame_count", out_cnt, EDGE ? 16 : 8);
    chk("stall_frame_mid", log_d[3][1], 24'h312111);
    ready_mode = 0;
    run(1, 5, 1, 0);
    chk("w1_count", out_cnt, EDGE ? 5 : 3);
    chk("w1_y2", log_d[2][0], 24'h201000);
    chk("w1_y4", log_d[4][0], 24'h403020);
    run(4, 2, 1, 0);
    chk("h2_count", out_cnt, EDGE ? 8 : 0);
    // reset in the middle of row 2
    start_frame(4, 4);
    feed(4, 1, 0, 9);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", px_out_valid, 0);
    chk("midrst_data", px_out_data, 0);
    chk("midrst_xy", {px_out_x, px_out_y, px_out_last_x, px_out_last_y}, 0);
    chk("midrst_status", {done, busy, px_in_ready}, 0);
    q.delete();
    base = done_cnt;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_done", done_cnt, base);
    chk("post_rst_idle", busy, 0);
    run(4, 4, 1, 0);
    chk("post_rst_count", out_cnt, EDGE ? 16 : 8);
    chk("post_rst_first", log_d[2][0], 24'h201000);
    ready_mode = 2;
    for (int n = 0; n < 8; n++) begin
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 9);
      run(w, h, 0, 1);
      chk("rand_count", out_cnt, EDGE ? w * h : (h >= ROWS ? w * (h - ROWS + 1) : 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/px_line_buffer.md
Name: px_line_buffer

Overview:
- Parametrised successor to the convolution-engine pixel ingest.
- Accepts a raster pixel stream over valid/ready and stores ROWS-1 previous lines in on-chip line RAMs.
- For each accepted pixel, emits a vertical column of ROWS pixels at the same x, tagged with position and last_x/last_y.
- Feeds the downstream KxK window/MAC stage; frame size comes from cfg_width/cfg_height, latched at start.

Parameters:
XB, 10, bits of x coordinate; line RAM depth 2**XB
YB, 10, bits of y coordinate
PB, 8, bits per pixel
ROWS, 3, column height (kernel rows), legal 2..8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse, begins a frame
cfg_width  in  XB  pixels per line, legal 1..2**XB-1
cfg_height  in  YB  lines per frame, legal >=1
px_in_data  in  PB  input pixel
px_in_valid  in  1  input valid
px_in_ready  out  1  input ready
px_out_data  out  ROWS*PB  column; slice i = row y-ROWS+1+i (index ROWS-1 is the newest row)
px_out_x  out  XB  x of column
px_out_y  out  YB  y of newest row
px_out_last_x  out  1  px_out_x == width-1
px_out_last_y  out  1  px_out_y == height-1
px_out_valid  out  1  output valid
px_out_ready  in  1  output ready
done  out  1  one-cycle pulse at frame end
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Line RAM contents are not reset; the row counter gates their use. Reset mid-frame aborts the frame; no done pulse.
- States:
  - IDLE: px_in_ready=0. On start with cfg_width!=0 and cfg_height!=0, latch the config, clear x/y, go to RUN. Start with a zero dimension is ignored.
  - RUN: px_in_ready = !px_out_valid || px_out_ready. Accept when valid&&ready. x increments and wraps to 0 at width-1, then y increments. Accepting the pixel (width-1, height-1) goes to FLUSH.
  - FLUSH: px_in_ready=0. Wait until the output register is empty or being accepted, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- On acceptance at (x,y):
  - Read all ROWS-1 line RAMs at address x; read-before-write.
  - Write the pixel into RAM slot wr_row at address x.
  - wr_row rotates mod ROWS-1 at each line end.
  - Capture the pixel, x and y into the stage register.
- Latency: px_out_valid asserts the cycle after acceptance.
- Output register holds data and flags stable while valid&&!ready. RAM read enable equals input acceptance, so RAM dout holds during a stall.
- Output is produced only when y >= ROWS-1. For earlier rows the pixel is written only, and px_out_valid is not set.
- Column assembly: a rotation mux orders the RAM outputs oldest-first from wr_row; the captured pixel goes in slice ROWS-1.
- If cfg_height < ROWS, the frame is consumed with no outputs and done still pulses.
- Throughput: 1 pixel/cycle with px_out_ready held high.
- Coordinate arithmetic is unsigned with no overflow; width-1 is compared at XB bits.

Optional Feature:
- Macro: PX_EDGE_REPLICATE_EN.
- Defined: every accepted pixel produces an output, including rows y < ROWS-1. Missing upper rows are replaced by the oldest valid row (top-edge clamp); row 0 fills all slices on y=0.
- Undefined: only y >= ROWS-1 produces output, as above.

Decomposition:
- Package conveng_pkg:
  - px_lb_state_t enum {IDLE, RUN, FLUSH, DONE}
  - pixel_t typedef (logic [PB-1:0]) and ROWS_MAX=8
- Sub-module px_line_ram: simple dual-port, depth 2**XB, width PB, synchronous read with read enable, read-before-write. Instantiated ROWS-1 times in a generate loop.

Test Plan:
- Frame 4x4, ROWS=3, px = y*16+x, ready held 1:
  - exactly 8 outputs;
  - first output x=0, y=2, data {0x00,0x10,0x20};
  - last output x=3, y=3, last_x=last_y=1, data {0x13,0x23,0x33};
  - done pulses 1 cycle after the last output is accepted.
- Same frame with px_out_ready toggling 1,0,0,1: output data stable during stalls, no pixel lost or duplicated, px_in_ready=0 while the output is stalled.
- Width=1, height=5: outputs at y=2..4 all with last_x=1; wr_row rotates correctly (column at y=4 = {0x20,0x30,0x40}).
- Height=2 with ROWS=3: 2*width pixels accepted, zero outputs, done pulses.
- Assert rst mid-frame at y=2: all outputs 0 immediately; a new start then runs a clean full frame; no stale done.
- With PX_EDGE_REPLICATE_EN, 4x4: 16 outputs; (x=1, y=0) gives {0x01,0x01,0x01}; (x=1, y=1) gives {0x01,0x01,0x11}.
